// File: rtl/exp6_pkg.sv
// Shared definitions for the exp6 game controller: state codes as 4-bit
// constants (these are also the db_estado debug values) and the state type.
package exp6_pkg;

    localparam logic [3:0] ST_INICIAL     = 4'h0;
    localparam logic [3:0] ST_PREPARA     = 4'h1;
    localparam logic [3:0] ST_ESPERA      = 4'h2;
    localparam logic [3:0] ST_REGISTRA    = 4'h4;
    localparam logic [3:0] ST_COMPARA     = 4'h5;
    localparam logic [3:0] ST_PROXIMO     = 4'h6;
    localparam logic [3:0] ST_FIM_ACERTO  = 4'hA;
    localparam logic [3:0] ST_FIM_ERRO    = 4'hE;
    localparam logic [3:0] ST_FIM_TIMEOUT = 4'hD;

    typedef enum logic [3:0] {
        INICIAL     = ST_INICIAL,
        PREPARA     = ST_PREPARA,
        ESPERA      = ST_ESPERA,
        REGISTRA    = ST_REGISTRA,
        COMPARA     = ST_COMPARA,
        PROXIMO     = ST_PROXIMO,
        FIM_ACERTO  = ST_FIM_ACERTO,
        FIM_ERRO    = ST_FIM_ERRO,
        FIM_TIMEOUT = ST_FIM_TIMEOUT
    } estado_t;

endpackage

// File: rtl/unidade_controle_exp6.sv
// Moore control unit for the exp6 memory game: waits for iniciar, clears the
// datapath, then for each of 16 positions waits for a player move, registers
// it, compares it with memory and either advances, wins or loses.
// Optional feature macro: TIMEOUT_EN (move timer counts in ESPERA and an
// expired timer ends the game in FIM_TIMEOUT). Without it the timer is never
// advanced, fimT is ignored and FIM_TIMEOUT is unreachable.
// Input handshake: jogada is a single-cycle pulse; it is acted on only in
// ESPERA and needs no acknowledge. iniciar is level-sampled and only matters
// in INICIAL and the FIM_* states.
module unidade_controle_exp6
    import exp6_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic       iniciar,
    input  logic       jogada,
    input  logic       igual,
    input  logic       fimC,
    input  logic       fimT,
    output logic       zeraC,
    output logic       zeraT,
    output logic       zeraR,
    output logic       contaC,
    output logic       contaT,
    output logic       registraR,
    output logic       pronto,
    output logic       acertou,
    output logic       errou,
    output logic       timeout,
    output logic [3:0] db_estado
);

    estado_t estado, prox_estado;

`ifdef TIMEOUT_EN
    localparam logic USA_TIMEOUT = 1'b1;
`else
    localparam logic USA_TIMEOUT = 1'b0;
    logic unused_fimt;
    assign unused_fimt = fimT;
`endif

    // State register; reset returns to INICIAL immediately, mid-game included.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) estado <= INICIAL;
        else       estado <= prox_estado;
    end

    // Next-state logic; a move in ESPERA takes priority over timer expiry.
    always_comb begin
        prox_estado = estado;
        case (estado)
            INICIAL:     if (iniciar) prox_estado = PREPARA;
            PREPARA:     prox_estado = ESPERA;
            ESPERA: begin
                if (jogada)                   prox_estado = REGISTRA;
                else if (USA_TIMEOUT && fimT) prox_estado = FIM_TIMEOUT;
            end
            REGISTRA:    prox_estado = COMPARA;
            COMPARA: begin
                if (!igual)    prox_estado = FIM_ERRO;
                else if (fimC) prox_estado = FIM_ACERTO;
                else           prox_estado = PROXIMO;
            end
            PROXIMO:     prox_estado = ESPERA;
            FIM_ACERTO,
            FIM_ERRO,
            FIM_TIMEOUT: if (iniciar) prox_estado = PREPARA;
            default:     prox_estado = INICIAL;
        endcase
    end

    // Output decode from the state alone; anything not set here stays 0.
    always_comb begin
        zeraC     = 1'b0;
        zeraT     = 1'b0;
        zeraR     = 1'b0;
        contaC    = 1'b0;
        contaT    = 1'b0;
        registraR = 1'b0;
        pronto    = 1'b0;
        acertou   = 1'b0;
        errou     = 1'b0;
        timeout   = 1'b0;
        case (estado)
            PREPARA: begin
                zeraC = 1'b1;
                zeraT = 1'b1;
                zeraR = 1'b1;
            end
            ESPERA:      contaT = USA_TIMEOUT;
            REGISTRA: begin
                registraR = 1'b1;
                zeraT     = 1'b1;
            end
            PROXIMO:     contaC = 1'b1;
            FIM_ACERTO: begin
                pronto  = 1'b1;
                acertou = 1'b1;
            end
            FIM_ERRO: begin
                pronto = 1'b1;
                errou  = 1'b1;
            end
            FIM_TIMEOUT: begin
                pronto  = 1'b1;
                timeout = USA_TIMEOUT;
            end
            default: ;
        endcase
    end

    assign db_estado = estado;

endmodule

// File: doc/unidade_controle_exp6.md
UNIDADE_CONTROLE_EXP6 -- requirements
Module: unidade_controle_exp6

Interface
Parameters: none.
REQ-001 The block SHALL have one clock and an asynchronous active-high reset: clock  in  1  system clock, rising edge; reset  in  1  asynchronous, active-high.
REQ-002 iniciar  in  1  starts a game; level-sampled.
REQ-003 jogada  in  1  one-cycle player-move pulse from the datapath edge detector.
REQ-004 igual  in  1  stored move equals memory word.
REQ-005 fimC  in  1  address counter at last position (15).
REQ-006 fimT  in  1  move timer expired.
REQ-007 zeraC, zeraT, zeraR  out  1 each  clear address counter, timer and move register.
REQ-008 contaC, contaT  out  1 each  advance address counter and timer.
REQ-009 registraR  out  1  load move register from switches.
REQ-010 pronto, acertou, errou, timeout  out  1 each  game finished; win; wrong move; time expired.
REQ-011 db_estado  out  4  current state code, for debug display.

Function
REQ-012 The FSM SHALL be Moore; every output SHALL be a function of the state only; an output not listed for a state SHALL be 0.
REQ-013 States/codes: INICIAL 0x0, PREPARA 0x1, ESPERA 0x2, REGISTRA 0x4, COMPARA 0x5, PROXIMO 0x6, FIM_ACERTO 0xA, FIM_ERRO 0xE, FIM_TIMEOUT 0xD; db_estado SHALL equal the code.
REQ-014 INICIAL: no outputs; iniciar=1 -> PREPARA, else stay.
REQ-015 PREPARA: zeraC=zeraT=zeraR=1 for exactly one cycle; -> ESPERA unconditionally.
REQ-016 ESPERA: contaT=1; jogada=1 -> REGISTRA; else fimT=1 -> FIM_TIMEOUT (TIMEOUT_EN only); else stay.
REQ-017 jogada and fimT asserted in the same ESPERA cycle SHALL resolve to REGISTRA (move wins).
REQ-018 REGISTRA: registraR=1, zeraT=1; -> COMPARA unconditionally.
REQ-019 COMPARA: igual=0 -> FIM_ERRO; igual=1 and fimC=1 -> FIM_ACERTO; igual=1 and fimC=0 -> PROXIMO.
REQ-020 PROXIMO: contaC=1 for exactly one cycle; -> ESPERA.
REQ-021 FIM_ACERTO: pronto=acertou=1; FIM_ERRO: pronto=errou=1; FIM_TIMEOUT: pronto=timeout=1.
REQ-022 In any FIM_* state, iniciar=1 -> PREPARA (restart), else stay; outputs held until exit.
REQ-023 iniciar SHALL be ignored in all states other than INICIAL and FIM_*.
REQ-024 Latency: jogada pulse at edge N -> registraR high in cycle N+1, result state entered at edge N+3 (or PROXIMO -> ESPERA at N+4).
REQ-025 Unreachable state codes SHALL transition to INICIAL on the next edge.

Reset
REQ-026 reset=1 SHALL force INICIAL asynchronously, regardless of state, including mid-game; all outputs 0, db_estado=0x0 while reset is high.
REQ-027 After reset release, the first transition SHALL occur on the first rising clock edge with iniciar=1.

Configuration
REQ-028 Macro TIMEOUT_EN: defined -> contaT asserted in ESPERA and fimT transition to FIM_TIMEOUT active; undefined -> contaT tied 0, fimT ignored, FIM_TIMEOUT unreachable, timeout tied 0 (state code remains reserved).

Structure
REQ-029 State codes (4-bit localparams) SHALL live in shared package exp6_pkg, reused by top-level and bench.
REQ-030 No sub-module; single module with state register, next-state logic and output decode.

Verification
REQ-031 Reset mid-game: in COMPARA assert reset asynchronously -> db_estado=0x0 before next edge, all outputs 0.
REQ-032 Full win: iniciar 1 cycle, 16 jogada pulses with igual=1, fimC=1 only on 16th -> 15 contaC pulses, ends FIM_ACERTO, pronto=acertou=1, db_estado=0xA.
REQ-033 Error: third move with igual=0 -> FIM_ERRO, errou=1, exactly 2 contaC pulses seen.
REQ-034 Timeout (TIMEOUT_EN): in ESPERA hold jogada=0, assert fimT -> FIM_TIMEOUT next edge, timeout=1, db_estado=0xD; without macro same stimulus -> stays 0x2.
REQ-035 Simultaneous jogada=1 and fimT=1 in ESPERA -> REGISTRA (0x4), registraR=1, zeraT=1.
REQ-036 Restart: from FIM_ERRO assert iniciar -> PREPARA with zeraC=zeraT=zeraR=1 for one cycle, then ESPERA.
